iq_sample_fifo: RTL and testbench

- Buffers the decimated quadrature baseband stream from the DDC (16-bit I/Q plus a one-cycle valid strobe at 19.5–156 kSPS) for a slower, bursty consumer (SPI/USB readout, CPU bus).
- Packs each I/Q pair into one 32-bit word and stores it in an inferred block-RAM FIFO.
- Provides a read-strobe interface, occupancy level, a flush control, and sticky overflow reporting with a dropped-sample count.

---
 rtl/iq_sample_fifo.sv | 122 ++++++++++++
 tb/tb_iq_sample_fifo.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/iq_sample_fifo.sv
// Block-RAM FIFO for packed {I,Q} baseband words between the DDC and a bursty reader.
// Tracks occupancy, supports flush, and counts samples dropped while full.
module iq_sample_fifo #(
    parameter int osz = 16,
    parameter int asz = 9,
    parameter int dsz = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               valid,
    input  logic [osz-1:0]     i_in,
    input  logic [osz-1:0]     q_in,
    input  logic               rd_ena,
    input  logic               flush,
    input  logic               ovf_clr,
    output logic [2*osz-1:0]   rd_data,
    output logic               rd_valid,
    output logic               empty,
    output logic               full,
    output logic [asz:0]       level,
    output logic               ovf,
    output logic [dsz-1:0]     drop_cnt
);

    localparam int depth = 1 << asz;
    localparam logic [asz:0] full_level = {1'b1, {asz{1'b0}}};

    logic [1:0]          run_sync;
    logic                run;
    logic [asz-1:0]      wptr;
    logic [asz-1:0]      rptr;
    logic                rd_acc;
    logic                wr_acc;
    logic                drop;
    logic [asz:0]        level_next;
    logic [2*osz-1:0]    mem [depth];

    // Pointers may only move once reset release has been seen by two flops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run_sync <= 2'b00;
        end else begin
            run_sync <= {run_sync[0], 1'b1};
        end
    end

    assign run = run_sync[1];

    always_comb begin
        rd_acc     = run && !flush && rd_ena && !empty;
        wr_acc     = run && !flush && valid && (!full || rd_acc);
        drop       = run && !flush && valid && full && !rd_acc;
        level_next = level;
        if (flush) begin
            level_next = '0;
        end else begin
            case ({wr_acc, rd_acc})
                2'b10:   level_next = level + 1'b1;
                2'b01:   level_next = level - 1'b1;
                default: level_next = level;
            endcase
        end
    end

    // Storage has no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wptr] <= {i_in, q_in};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr     <= '0;
            rptr     <= '0;
            level    <= '0;
            empty    <= 1'b1;
            full     <= 1'b0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            if (flush) begin
                wptr <= '0;
                rptr <= '0;
            end else begin
                if (wr_acc) begin
                    wptr <= wptr + 1'b1;
                end
                if (rd_acc) begin
                    rptr <= rptr + 1'b1;
                end
            end
            // When full, a same-cycle write to rptr's slot still returns the old word here.
            rd_valid <= rd_acc;
            if (rd_acc) begin
                rd_data <= mem[rptr];
            end
            level <= level_next;
            empty <= (level_next == '0);
            full  <= (level_next == full_level);
        end
    end

    // A drop in the same cycle as ovf_clr restarts the count at one.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf      <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            ovf <= 1'b1;
            if (ovf_clr) begin
                drop_cnt <= {{(dsz-1){1'b0}}, 1'b1};
            end else if (!(&drop_cnt)) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
        end else if (ovf_clr) begin
            ovf      <= 1'b0;
            drop_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_iq_sample_fifo.sv
// Randomised bench for iq_sample_fifo against a queue-based model of the FIFO rules.
module tb_iq_sample_fifo;

    localparam int DEPTH = 512;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        valid = 1'b0;
    logic [15:0] i_in = '0;
    logic [15:0] q_in = '0;
    logic        rd_ena = 1'b0;
    logic        flush = 1'b0;
    logic        ovf_clr = 1'b0;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        empty;
    logic        full;
    logic [9:0]  level;
    logic        ovf;
    logic [7:0]  drop_cnt;

    logic [31:0] model_q[$];
    logic [31:0] exp_data = '0;
    logic        exp_rvalid = 1'b0;
    logic        exp_ovf = 1'b0;
    int          exp_drop = 0;
    int          checks = 0;
    int          failures = 0;

    iq_sample_fifo dut (
        .clk      (clk),
        .reset    (reset),
        .valid    (valid),
        .i_in     (i_in),
        .q_in     (q_in),
        .rd_ena   (rd_ena),
        .flush    (flush),
        .ovf_clr  (ovf_clr),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .empty    (empty),
        .full     (full),
        .level    (level),
        .ovf      (ovf),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    // One clock of stimulus; the model applies the FIFO rules to the queue at the edge.
    task automatic step(input logic v, input logic [15:0] i, input logic [15:0] q,
                        input logic rd, input logic fl, input logic oc);
        int n;
        bit r_ok, w_ok, dr;
        int base;
        @(negedge clk);
        valid = v; i_in = i; q_in = q; rd_ena = rd; flush = fl; ovf_clr = oc;
        @(posedge clk);
        if (reset) begin
            n    = model_q.size();
            r_ok = rd && (n > 0) && !fl;
            w_ok = v && !fl && ((n < DEPTH) || r_ok);
            dr   = v && !fl && (n == DEPTH) && !r_ok;
            exp_rvalid = r_ok;
            if (fl) begin
                model_q.delete();
            end else begin
                if (r_ok) exp_data = model_q.pop_front();
                if (w_ok) model_q.push_back({i, q});
            end
            if (dr) begin
                exp_ovf  = 1'b1;
                base     = oc ? 0 : exp_drop;
                exp_drop = (base >= 255) ? 255 : base + 1;
            end else if (oc) begin
                exp_ovf  = 1'b0;
                exp_drop = 0;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            valid = 1'($urandom); rd_ena = 1'($urandom); flush = 1'($urandom);
            ovf_clr = 1'($urandom); i_in = 16'($urandom); q_in = 16'($urandom);
            @(negedge clk);
            checks++;
            if (empty !== 1'b1 || full !== 1'b0 || level !== 10'd0 || rd_valid !== 1'b0 ||
                rd_data !== 32'd0 || ovf !== 1'b0 || drop_cnt !== 8'd0) begin
                failures++;
                $display("[TB] FAIL reset_hold: empty=%b full=%b level=%0d rv=%b data=%h ovf=%b drop=%0d, required 1 0 0 0 0 0 0",
                         empty, full, level, rd_valid, rd_data, ovf, drop_cnt);
            end
        end
        @(negedge clk);
        valid = 0; rd_ena = 0; flush = 0; ovf_clr = 0;
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step(0, 16'h0, 16'h0, 0, 0, 0);
            checks++;
            if (empty !== 1'b1 || level !== 10'd0 || rd_valid !== 1'b0 || ovf !== 1'b0 || drop_cnt !== 8'd0) begin
                failures++;
                $display("[TB] FAIL reset_idle: empty=%b level=%0d rv=%b ovf=%b drop=%0d, required 1 0 0 0 0",
                         empty, level, rd_valid, ovf, drop_cnt);
            end
        end
    endtask

    task automatic test_basic_order();
        logic [15:0] iv[3];
        logic [15:0] qv[3];
        logic [31:0] words[3];
        iv = '{16'h1234, 16'h7FFF, 16'h0001};
        qv = '{16'hABCD, 16'h8000, 16'hFFFF};
        words = '{32'h1234ABCD, 32'h7FFF8000, 32'h0001FFFF};
        for (int k = 0; k < 3; k++) begin
            step(1, iv[k], qv[k], 0, 0, 0);
            checks++;
            if (level !== 10'(k + 1) || empty !== 1'b0) begin
                failures++;
                $display("[TB] FAIL order_fill: level=%0d empty=%b, required %0d 0", level, empty, k + 1);
            end
        end
        for (int k = 0; k < 3; k++) begin
            step(0, 16'h0, 16'h0, 1, 0, 0);
            checks++;
            if (rd_valid !== 1'b1 || rd_data !== words[k] || rd_data !== exp_data || level !== 10'(2 - k)) begin
                failures++;
                $display("[TB] FAIL order_read: rv=%b data=%h level=%0d, required 1 %h %0d",
                         rd_valid, rd_data, level, words[k], 2 - k);
            end
        end
        checks++;
        if (empty !== 1'b1) begin
            failures++;
            $display("[TB] FAIL order_empty: empty=%b, required 1", empty);
        end
        step(0, 16'h0, 16'h0, 1, 0, 0);
        checks++;
        if (rd_valid !== 1'b0 || rd_data !== 32'h0001FFFF) begin
            failures++;
            $display("[TB] FAIL order_extra_read: rv=%b data=%h, required 0 0001ffff", rd_valid, rd_data);
        end
    endtask

    task automatic fill_to_full();
        while (model_q.size() < DEPTH) step(1, 16'($urandom), 16'($urandom), 0, 0, 0);
    endtask

    task automatic test_overflow();
        fill_to_full();
        checks++;
        if (full !== 1'b1 || level !== 10'd512) begin
            failures++;
            $display("[TB] FAIL ovf_full: full=%b level=%0d, required 1 512", full, level);
        end
        for (int k = 0; k < 3; k++) step(1, 16'($urandom), 16'($urandom), 0, 0, 0);
        checks++;
        if (ovf !== 1'b1 || drop_cnt !== 8'd3 || level !== 10'd512) begin
            failures++;
            $display("[TB] FAIL ovf_drops: ovf=%b drop=%0d level=%0d, required 1 3 512", ovf, drop_cnt, level);
        end
        for (int k = 0; k < DEPTH; k++) begin
            step(0, 16'h0, 16'h0, 1, 0, 0);
            checks++;
            if (rd_valid !== 1'b1 || rd_data !== exp_data) begin
                failures++;
                $display("[TB] FAIL ovf_readback[%0d]: rv=%b data=%h, required 1 %h", k, rd_valid, rd_data, exp_data);
            end
        end
        checks++;
        if (empty !== 1'b1 || level !== 10'd0) begin
            failures++;
            $display("[TB] FAIL ovf_drained: empty=%b level=%0d, required 1 0", empty, level);
        end
    endtask

    task automatic test_full_concurrent();
        fill_to_full();
        for (int k = 0; k < 10; k++) begin
            step(1, 16'($urandom), 16'($urandom), 1, 0, 0);
            checks++;
            if (level !== 10'd512 || full !== 1'b1 || drop_cnt !== 8'(exp_drop) ||
                rd_valid !== 1'b1 || rd_data !== exp_data) begin
                failures++;
                $display("[TB] FAIL concurrent[%0d]: level=%0d full=%b drop=%0d rv=%b data=%h, required 512 1 %0d 1 %h",
                         k, level, full, drop_cnt, rd_valid, rd_data, exp_drop, exp_data);
            end
        end
    endtask

    task automatic test_flush_clear();
        step(0, 16'h0, 16'h0, 0, 1, 0);
        for (int k = 0; k < 100; k++) step(1, 16'($urandom), 16'($urandom), 0, 0, 0);
        checks++;
        if (level !== 10'd100) begin
            failures++;
            $display("[TB] FAIL flush_fill: level=%0d, required 100", level);
        end
        step(1, 16'($urandom), 16'($urandom), 1, 1, 0);
        checks++;
        if (level !== 10'd0 || empty !== 1'b1 || rd_valid !== 1'b0 || ovf !== 1'b1 || drop_cnt !== 8'(exp_drop)) begin
            failures++;
            $display("[TB] FAIL flush: level=%0d empty=%b rv=%b ovf=%b drop=%0d, required 0 1 0 1 %0d",
                     level, empty, rd_valid, ovf, drop_cnt, exp_drop);
        end
        fill_to_full();
        step(1, 16'($urandom), 16'($urandom), 0, 0, 1);
        checks++;
        if (ovf !== 1'b1 || drop_cnt !== 8'd1 || exp_drop != 1) begin
            failures++;
            $display("[TB] FAIL clr_vs_drop: ovf=%b drop=%0d, required 1 1", ovf, drop_cnt);
        end
        step(0, 16'h0, 16'h0, 0, 0, 1);
        checks++;
        if (ovf !== 1'b0 || drop_cnt !== 8'd0) begin
            failures++;
            $display("[TB] FAIL clr: ovf=%b drop=%0d, required 0 0", ovf, drop_cnt);
        end
    endtask

    task automatic test_stream_wrap();
        int writes = 0;
        int cycles = 0;
        bit v, rd;
        step(0, 16'h0, 16'h0, 0, 1, 0);
        while (writes < 2000 && cycles < 20000) begin
            v  = (model_q.size() < 3) && ($urandom_range(0, 3) != 0);
            rd = (model_q.size() >= 2) || ($urandom_range(0, 1) == 1);
            if (v) writes++;
            step(v, 16'($urandom), 16'($urandom), rd, 0, 0);
            cycles++;
            checks++;
            if (level !== 10'(model_q.size()) || rd_valid !== exp_rvalid || rd_data !== exp_data) begin
                failures++;
                $display("[TB] FAIL stream[%0d]: level=%0d rv=%b data=%h, required %0d %b %h",
                         cycles, level, rd_valid, rd_data, model_q.size(), exp_rvalid, exp_data);
            end
        end
        checks++;
        if (writes < 2000) begin
            failures++;
            $display("[TB] FAIL stream_budget: writes=%0d, required 2000", writes);
        end
        step(0, 16'h0, 16'h0, 0, 0, 1);
        fill_to_full();
        for (int k = 0; k < 300; k++) step(1, 16'($urandom), 16'($urandom), 0, 0, 0);
        checks++;
        if (drop_cnt !== 8'd255 || drop_cnt !== 8'(exp_drop) || ovf !== 1'b1 || level !== 10'd512) begin
            failures++;
            $display("[TB] FAIL saturate: drop=%0d ovf=%b level=%0d, required 255 1 512", drop_cnt, ovf, level);
        end
    endtask

    initial begin
        $display("[TB] iq_sample_fifo bench start");
        test_reset();
        test_basic_order();
        test_overflow();
        test_full_concurrent();
        test_flush_clear();
        test_stream_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
